// File: rtl/trap_unit.sv
// Machine-mode trap/CSR unit: captures decode exceptions and MRET, flushes the pipe,
// then issues a one-cycle fetch redirect to mtvec (trap) or mepc (MRET).
module trap_unit #(
  parameter logic [31:0] MTVEC_RST    = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exceptionD,
  input  logic [4:0]  causeD,
  input  logic [31:0] mtvalD,
  input  logic [31:0] PCD,
  input  logic        mretD,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirectPC,
  output logic        trap_busy
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        tgt_q, tgt_d;
  logic               mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0]        mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic               take_trap, take_mret;

  assign take_trap = (state_q == IDLE) && exceptionD;
  assign take_mret = (state_q == IDLE) && mretD && !exceptionD;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          mie_d  = csr_wdata[3];
          mpie_d = csr_wdata[7];
        end
        12'h305: mtvec_d    = csr_wdata & ALIGN_MASK;
        12'h340: mscratch_d = csr_wdata;
        12'h341: mepc_d     = csr_wdata & ALIGN_MASK;
        12'h342: mcause_d   = csr_wdata;
        12'h343: mtval_d    = csr_wdata;
        default: ;
      endcase
    end

    // Hardware updates are applied last so they override a colliding CSR write.
    if (take_trap) begin
      mepc_d   = PCD & ALIGN_MASK;
      mcause_d = {27'b0, causeD};
      mtval_d  = mtvalD;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      tgt_d    = mtvec_q;
      cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
      state_d  = FLUSH;
    end else if (take_mret) begin
      mie_d   = mpie_q;
      mpie_d  = 1'b1;
      tgt_d   = mepc_q;
      cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      state_d = FLUSH;
    end

    case (state_q)
      FLUSH: begin
        if (cnt_q == '0) state_d = REDIR;
        else             cnt_d   = cnt_q - 1'b1;
      end
      REDIR:   state_d = IDLE;
      default: ;
    endcase
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      default: csr_rdata = 32'h0;
    endcase
  end

  assign flush      = (state_q != IDLE);
  assign redirect   = (state_q == REDIR);
  assign redirectPC = (state_q == REDIR) ? tgt_q : 32'h0;
  assign trap_busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tgt_q      <= 32'h0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: CSR vector table, directed trap/MRET/reset
// sequences, and a randomized phase checked against a timeline-based reference model.
module tb_trap_unit;

  localparam int FC = 2;
  localparam logic [31:0] MTVEC_INIT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        exceptionD;
  logic [4:0]  causeD;
  logic [31:0] mtvalD;
  logic [31:0] PCD;
  logic        mretD;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        flush;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        trap_busy;

  trap_unit #(.MTVEC_RST(MTVEC_INIT), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .exceptionD(exceptionD), .causeD(causeD), .mtvalD(mtvalD),
    .PCD(PCD), .mretD(mretD), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .flush(flush), .redirect(redirect), .redirectPC(redirectPC),
    .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: CSR contents plus the cycle window during which the unit is busy.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_target;
  int          m_bstart, m_bend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic m_busy();
    return (cyc >= m_bstart) && (cyc <= m_bend);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] n_ms, n_tv, n_sc, n_ep, n_ca, n_tval;
    logic idle, tk_trap, tk_mret;
    if (rst) begin
      m_mstatus = 0; m_mtvec = MTVEC_INIT; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_target = 0; m_bstart = 0; m_bend = -1;
      return;
    end
    idle    = !m_busy();
    tk_trap = idle && exceptionD;
    tk_mret = idle && mretD && !exceptionD;
    n_ms = m_mstatus; n_tv = m_mtvec; n_sc = m_mscratch;
    n_ep = m_mepc; n_ca = m_mcause; n_tval = m_mtval;
    if (csr_we) begin
      case (csr_addr)
        12'h300: n_ms   = csr_wdata & 32'h88;
        12'h305: n_tv   = csr_wdata & ~32'h3;
        12'h340: n_sc   = csr_wdata;
        12'h341: n_ep   = csr_wdata & ~32'h3;
        12'h342: n_ca   = csr_wdata;
        12'h343: n_tval = csr_wdata;
        default: ;
      endcase
    end
    if (tk_trap) begin
      n_ep     = PCD & ~32'h3;
      n_ca     = 32'(causeD);
      n_tval   = mtvalD;
      n_ms     = (m_mstatus & 32'h8) != 0 ? 32'h80 : 32'h0;
      m_target = m_mtvec;
      m_bstart = cyc + 1;
      m_bend   = cyc + 1 + FC;
    end else if (tk_mret) begin
      n_ms     = 32'h80 | ((m_mstatus & 32'h80) != 0 ? 32'h8 : 32'h0);
      m_target = m_mepc;
      m_bstart = cyc + 1;
      m_bend   = cyc + 1 + FC;
    end
    m_mstatus = n_ms; m_mtvec = n_tv; m_mscratch = n_sc;
    m_mepc = n_ep; m_mcause = n_ca; m_mtval = n_tval;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    rst = 0; exceptionD = 0; causeD = 0; mtvalD = 0; PCD = 0; mretD = 0;
    csr_addr = 0; csr_we = 0; csr_wdata = 0;
  endtask

  task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    csr_we   = 0;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  // Checks the cycles following an accept: flush for FC+1 cycles, redirect on the last.
  task automatic run_seq(input string name, input logic [31:0] target, input bit inject);
    for (int k = 1; k <= FC + 2; k++) begin
      chk({name, ".flush"},      32'(flush),     32'(k <= FC + 1));
      chk({name, ".redirect"},   32'(redirect),  32'(k == FC + 1));
      chk({name, ".redirectPC"}, redirectPC,     (k == FC + 1) ? target : 32'h0);
      chk({name, ".busy"},       32'(trap_busy), 32'(k <= FC + 1));
      if (inject && k == 1) begin
        exceptionD = 1; mretD = 1; PCD = 32'h80; causeD = 5'd7;
      end
      tick();
      exceptionD = 0; mretD = 0;
    end
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t vecs[10];
  logic [11:0] addrs[8];

  initial begin
    vecs[0] = '{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{12'h341, 32'h0000_1237, 32'h0000_1234};
    vecs[2] = '{12'h342, 32'h0000_001F, 32'h0000_001F};
    vecs[3] = '{12'h343, 32'h0000_A5A5, 32'h0000_A5A5};
    vecs[4] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
    vecs[5] = '{12'h7C0, 32'h0000_FFFF, 32'h0000_0000};
    vecs[6] = '{12'h301, 32'h0000_0005, 32'h0000_0000};
    vecs[7] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[8] = '{12'h305, 32'h0000_2003, 32'h0000_2000};
    vecs[9] = '{12'h300, 32'h0000_0008, 32'h0000_0008};
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0, 12'h000};

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    chk("rst.flush",    32'(flush),     32'h0);
    chk("rst.redirect", 32'(redirect),  32'h0);
    chk("rst.busy",     32'(trap_busy), 32'h0);
    chk("rst.rpc",      redirectPC,     32'h0);
    chk_csr("rst.mtvec",    12'h305, 32'h100);
    chk_csr("rst.mstatus",  12'h300, 32'h0);
    chk_csr("rst.mscratch", 12'h340, 32'h0);
    chk_csr("rst.mepc",     12'h341, 32'h0);
    chk_csr("rst.mcause",   12'h342, 32'h0);
    chk_csr("rst.mtval",    12'h343, 32'h0);

    // CSR write/readback table
    for (int i = 0; i < 10; i++) begin
      csr_addr = vecs[i].addr; csr_we = 1; csr_wdata = vecs[i].wdata;
      tick();
      chk_csr($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Trap entry
    exceptionD = 1; causeD = 5'd2; mtvalD = 32'h7F; PCD = 32'h40;
    tick();
    exceptionD = 0;
    run_seq("trap", 32'h2000, 0);
    chk_csr("trap.mepc",    12'h341, 32'h40);
    chk_csr("trap.mcause",  12'h342, 32'h2);
    chk_csr("trap.mtval",   12'h343, 32'h7F);
    chk_csr("trap.mstatus", 12'h300, 32'h80);

    // MRET
    mretD = 1;
    tick();
    mretD = 0;
    run_seq("mret", 32'h40, 0);
    chk_csr("mret.mstatus", 12'h300, 32'h88);

    // Exception and MRET together; second exception during FLUSH ignored
    exceptionD = 1; mretD = 1; causeD = 5'd2; PCD = 32'h60;
    tick();
    exceptionD = 0; mretD = 0;
    run_seq("both", 32'h2000, 1);
    chk_csr("both.mepc",    12'h341, 32'h60);
    chk_csr("both.mcause",  12'h342, 32'h2);
    chk_csr("both.mstatus", 12'h300, 32'h80);

    // Reset in the first FLUSH cycle
    exceptionD = 1; causeD = 5'd2; PCD = 32'h44;
    tick();
    exceptionD = 0;
    chk("rstmid.flush_before", 32'(flush), 32'h1);
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < FC + 3; k++) begin
      chk("rstmid.flush",    32'(flush),    32'h0);
      chk("rstmid.redirect", 32'(redirect), 32'h0);
      tick();
    end
    chk_csr("rstmid.mepc",  12'h341, 32'h0);
    chk_csr("rstmid.mtvec", 12'h305, 32'h100);

    // CSR write colliding with capture, then unmapped access
    exceptionD = 1; causeD = 5'd2; PCD = 32'h48;
    csr_addr = 12'h341; csr_we = 1; csr_wdata = 32'h500;
    tick();
    exceptionD = 0; csr_we = 0;
    run_seq("coll", 32'h100, 0);
    chk_csr("coll.mepc", 12'h341, 32'h48);
    csr_addr = 12'h7C0; csr_we = 1; csr_wdata = 32'hFFFF;
    tick();
    chk_csr("unmapped", 12'h7C0, 32'h0);

    // Randomized phase against the reference model
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      exceptionD = ($urandom_range(0, 5) == 0);
      mretD      = ($urandom_range(0, 5) == 0);
      causeD     = 5'($urandom);
      mtvalD     = $urandom;
      PCD        = $urandom;
      csr_addr   = addrs[$urandom_range(0, 7)];
      csr_we     = ($urandom_range(0, 2) == 0);
      csr_wdata  = $urandom;
      #1;
      chk("rnd.flush",    32'(flush),     32'(m_busy()));
      chk("rnd.busy",     32'(trap_busy), 32'(m_busy()));
      chk("rnd.redirect", 32'(redirect),  32'(m_busy() && cyc == m_bend));
      chk("rnd.rpc",      redirectPC,     (m_busy() && cyc == m_bend) ? m_target : 32'h0);
      chk("rnd.rdata",    csr_rdata,      m_read(csr_addr));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
